// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Width codes, FSM encoding and latency range helper.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  function automatic bit latency_ok(int lat);
    return (lat >= 1) && (lat <= 15);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between core (master) and memory (slave).
// Request and response channels each use valid/ready.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder_lsu_align.sv
// Byte-lane steering and load extension for RV32 accesses.
// Range checking is left to the caller.
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_lo,
  input  logic [2:0]  i_funct3,
  input  logic        i_we,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic        o_err,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rword[{i_lo, 3'b000} +: 8];
  assign w_half = i_lo[1] ? i_rword[31:16]
                          : i_rword[15:0];

  always_comb begin
    o_err   = 1'b0;
    o_be    = 4'b0000;
    o_wdata = 32'd0;
    o_rdata = 32'd0;
    case (i_funct3)
      F3_B: begin
        o_be    = 4'b0001 << i_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_byte[7]}}, w_byte};
      end
      F3_BU: begin
        o_err   = i_we;
        o_rdata = {24'd0, w_byte};
      end
      F3_H: begin
        o_err   = i_lo[0];
        o_be    = i_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_half[15]}}, w_half};
      end
      F3_HU: begin
        o_err   = i_we | i_lo[0];
        o_rdata = {16'd0, w_half};
      end
      F3_W: begin
        o_err   = |i_lo;
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rword;
      end
      default: o_err = 1'b1;
    endcase
    // stores return zero; loads never write
    if (i_we) o_rdata = 32'd0;
    else      o_be    = 4'b0000;
    if (o_err) begin
      o_be    = 4'b0000;
      o_rdata = 32'd0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory answering the core's load/store port.
// One request in flight; response after LATENCY cycles.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic               clk,
  input logic               rst,
  dmem_responder_if.slave   bus
);

  localparam int AW   = $clog2(DEPTH_WORDS);
  localparam bit LIVE = (LATENCY == 1);

  if (!latency_ok(LATENCY)) begin : g_bad_lat
    $error("dmem_responder: LATENCY out of range");
  end

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_f3;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_accept, w_commit, w_wr;
  logic          w_we;
  logic [31:0]   w_addr, w_wdata;
  logic [2:0]    w_f3;
  logic [AW-1:0] w_idx;
  logic          w_oor, w_aerr, w_err;
  logic [3:0]    w_be;
  logic [31:0]   w_wsh, w_rsh, w_rword;

  // single-cycle latency commits straight from the request bus
  assign w_we    = LIVE ? bus.req_we     : r_we;
  assign w_addr  = LIVE ? bus.req_addr   : r_addr;
  assign w_wdata = LIVE ? bus.req_wdata  : r_wdata;
  assign w_f3    = LIVE ? bus.req_funct3 : r_f3;

  assign w_idx   = w_addr[AW+1:2];
  assign w_oor   = |w_addr[31:AW+2];
  assign w_err   = w_oor | w_aerr;
  assign w_rword = r_mem[w_idx];
  assign w_wr    = w_commit & ~rst & ~w_err & w_we;

  lsu_align u_align (
    .i_lo     (w_addr[1:0]),
    .i_funct3 (w_f3),
    .i_we     (w_we),
    .i_wdata  (w_wdata),
    .i_rword  (w_rword),
    .o_err    (w_aerr),
    .o_be     (w_be),
    .o_wdata  (w_wsh),
    .o_rdata  (w_rsh)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid && !rst) begin
          w_accept = 1'b1;
          if (LIVE) begin
            w_commit    = 1'b1;
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = 4'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_commit    = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_f3    <= 3'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_f3    <= bus.req_funct3;
      end
      if (w_commit) begin
        r_rdata <= w_err ? 32'd0 : w_rsh;
        r_err   <= w_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wsh[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = (r_state == IDLE) & ~rst;
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

endmodule
